// File: rtl/trng_collector.sv
// -----------------------------------------------------------------------------
// trng_collector
// Consumer side of the ring-oscillator entropy source. The asynchronous raw
// bit is synchronised, sampled every div+1 clocks, von Neumann debiased and
// packed into WORD_WIDTH-bit words, while a repetition-count test watches the
// raw samples.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   en             collection enable (registered once before use)
//   raw_bit        asynchronous ring-oscillator output
//   div            sample period is div+1 clocks
//   out_data       debiased word
//   out_valid      out_data holds an unconsumed word
//   out_ready      consumer accepts the word when out_valid && out_ready
//   health_fail    sticky repetition-test failure
//   overrun        sticky: a completed word was dropped
//   clear_err      clears sticky flags and all collection state
//   sample_strobe  one-cycle pulse on each raw sample
// -----------------------------------------------------------------------------
module trng_collector #(
   parameter int SYNC_STAGES = 2,
   parameter int DIV_WIDTH   = 8,
   parameter int WORD_WIDTH  = 8,
   parameter int REP_LIMIT   = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  raw_bit,
   input  logic [DIV_WIDTH-1:0]  div,
   output logic [WORD_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  health_fail,
   output logic                  overrun,
   input  logic                  clear_err,
   output logic                  sample_strobe
);

   localparam int CNT_W = (WORD_WIDTH > 2) ? $clog2(WORD_WIDTH) : 1;
   localparam int REP_W = 8;
   localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

   typedef enum logic {ST_FIRST = 1'b0, ST_SECOND = 1'b1} db_state_t;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   en_q, en_d;
   logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
   logic [DIV_WIDTH-1:0]   div_lat_q, div_lat_d;
   db_state_t              state_q, state_d;
   logic                   b0_q, b0_d;
   logic [WORD_WIDTH-1:0]  shift_q, shift_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [REP_W-1:0]       rep_q, rep_d;
   logic                   last_q, last_d;
   logic                   health_fail_q, health_fail_d;
   logic                   overrun_q, overrun_d;
   logic [WORD_WIDTH-1:0]  out_data_q, out_data_d;
   logic                   out_valid_q, out_valid_d;

   logic                   sync_bit_s;
   logic                   strobe_s;
   logic                   complete_s;
   logic [WORD_WIDTH-1:0]  word_s;
   logic [REP_W-1:0]       rep_next_s;

   assign sync_bit_s = sync_q[SYNC_STAGES-1];
   // en is registered so that every output, sample_strobe included, is a
   // function of flops only and stays 0 throughout reset.
   assign strobe_s   = en_q && (div_cnt_q == div_lat_q);

   // Synchroniser shift and enable register.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], raw_bit};
      en_d   = en;
   end

   // Sample-rate divider; the period is re-latched only at a wrap (or while
   // idle), so a div change never produces a short or long odd period.
   always_comb begin
      div_cnt_d = div_cnt_q;
      div_lat_d = div_lat_q;
      if (!en_q) begin
         div_cnt_d = '0;
         div_lat_d = div;
      end else if (strobe_s) begin
         div_cnt_d = '0;
         div_lat_d = div;
      end else begin
         div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
      end
   end

   // Repetition count including the current sample; rep_q == 0 means no
   // sample has been seen since the last clear.
   always_comb begin
      rep_next_s = rep_q;
      if ((rep_q == '0) || (sync_bit_s != last_q)) begin
         rep_next_s = REP_W'(1);
      end else if (rep_q == REP_MAX) begin
         rep_next_s = rep_q;
      end else begin
         rep_next_s = rep_q + REP_W'(1);
      end
   end

   // Debiaser FSM, word assembly, health test and output buffer.
   always_comb begin
      state_d       = state_q;
      b0_d          = b0_q;
      shift_d       = shift_q;
      bit_cnt_d     = bit_cnt_q;
      rep_d         = rep_q;
      last_d        = last_q;
      health_fail_d = health_fail_q;
      overrun_d     = overrun_q;
      out_data_d    = out_data_q;
      out_valid_d   = out_valid_q;
      complete_s    = 1'b0;
      word_s        = {shift_q[WORD_WIDTH-2:0], b0_q};

      if (clear_err) begin
         state_d       = ST_FIRST;
         b0_d          = 1'b0;
         shift_d       = '0;
         bit_cnt_d     = '0;
         rep_d         = '0;
         last_d        = 1'b0;
         health_fail_d = 1'b0;
         overrun_d     = 1'b0;
      end else if (!en_q) begin
         state_d   = ST_FIRST;
         b0_d      = 1'b0;
         shift_d   = '0;
         bit_cnt_d = '0;
         rep_d     = '0;
         last_d    = 1'b0;
      end else begin
         if (strobe_s) begin
            rep_d  = rep_next_s;
            last_d = sync_bit_s;
            if (rep_next_s == REP_MAX) begin
               health_fail_d = 1'b1;
            end else begin
               health_fail_d = health_fail_q;
            end
         end else begin
            rep_d = rep_q;
         end

         if (health_fail_q) begin
            state_d   = ST_FIRST;
            shift_d   = '0;
            bit_cnt_d = '0;
         end else if (strobe_s) begin
            case (state_q)
               ST_FIRST: begin
                  b0_d    = sync_bit_s;
                  state_d = ST_SECOND;
               end
               ST_SECOND: begin
                  state_d = ST_FIRST;
                  if (b0_q != sync_bit_s) begin
                     if (bit_cnt_q == LAST_BIT) begin
                        complete_s = 1'b1;
                        shift_d    = '0;
                        bit_cnt_d  = '0;
                     end else begin
                        shift_d   = word_s;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                     end
                  end else begin
                     shift_d = shift_q;
                  end
               end
               default: begin
                  state_d = ST_FIRST;
               end
            endcase
         end else begin
            state_d = state_q;
         end
      end

      if (health_fail_q) begin
         out_valid_d = 1'b0;
      end else if (complete_s) begin
         if (!out_valid_q || out_ready) begin
            out_data_d  = word_s;
            out_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q        <= '0;
         en_q          <= 1'b0;
         div_cnt_q     <= '0;
         div_lat_q     <= '0;
         state_q       <= ST_FIRST;
         b0_q          <= 1'b0;
         shift_q       <= '0;
         bit_cnt_q     <= '0;
         rep_q         <= '0;
         last_q        <= 1'b0;
         health_fail_q <= 1'b0;
         overrun_q     <= 1'b0;
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
      end else begin
         sync_q        <= sync_d;
         en_q          <= en_d;
         div_cnt_q     <= div_cnt_d;
         div_lat_q     <= div_lat_d;
         state_q       <= state_d;
         b0_q          <= b0_d;
         shift_q       <= shift_d;
         bit_cnt_q     <= bit_cnt_d;
         rep_q         <= rep_d;
         last_q        <= last_d;
         health_fail_q <= health_fail_d;
         overrun_q     <= overrun_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
      end
   end

   assign out_data      = out_data_q;
   assign out_valid     = out_valid_q;
   assign health_fail   = health_fail_q;
   assign overrun       = overrun_q;
   assign sample_strobe = strobe_s;

endmodule
